// File: rtl/fractal_sync_pkg.sv
// fractal_sync_pkg: shared response type, slot update kinds and group-size popcount
package fractal_sync_pkg;
  typedef struct packed {
    logic valid;
    logic done;
    logic ovf;
    logic id_err;
    logic merged;
  } resp_t;
  typedef enum logic [1:0] {PEND, DONE, OVF} upd_e;
  function automatic int unsigned popcount(input logic [31:0] v);
    popcount = 0;
    for (int i = 0; i < 32; i++) popcount += 32'(v[i]);
  endfunction
endpackage

// File: rtl/fractal_sync_port_merge.sv
// fractal_sync_port_merge: id validation and same-id grouping of request ports
module fractal_sync_port_merge
  import fractal_sync_pkg::*;
#(
  parameter int N_REGS    = 4,
  parameter int ID_WIDTH  = 2,
  parameter int N_PORTS   = 2,
  parameter int CNT_WIDTH = 3
) (
  input  logic [N_PORTS-1:0]                req_i,
  input  logic [N_PORTS-1:0][ID_WIDTH-1:0]  id_i,
  output logic [N_PORTS-1:0]                valid_o,
  output logic [N_PORTS-1:0]                id_err_o,
  output logic [N_PORTS-1:0]                leader_o,
  output logic [N_PORTS-1:0]                merged_o,
  output logic [N_PORTS-1:0][CNT_WIDTH-1:0] inc_o
);
  localparam logic [ID_WIDTH:0] NR = (ID_WIDTH+1)'(N_REGS);
  logic [N_PORTS-1:0][N_PORTS-1:0] grp;
  for (genvar p = 0; p < N_PORTS; p++) begin : g_port
    localparam logic [N_PORTS-1:0] LOW = (N_PORTS'(1) << p) - N_PORTS'(1);
    assign valid_o[p]  = req_i[p] && ({1'b0, id_i[p]} < NR);
    assign id_err_o[p] = req_i[p] && !valid_o[p];
    for (genvar q = 0; q < N_PORTS; q++) begin : g_peer
      assign grp[p][q] = valid_o[q] && (id_i[q] == id_i[p]);
    end
    // a port leads its group when no lower-index port shares its id
    assign leader_o[p] = valid_o[p] && ((grp[p] & LOW) == '0);
    assign merged_o[p] = valid_o[p] && !leader_o[p];
    assign inc_o[p]    = valid_o[p] ? CNT_WIDTH'(popcount(32'(grp[p]))) : '0;
  end
endmodule

// File: rtl/fractal_sync_cnt_local_rf.sv
// fractal_sync_cnt_local_rf: multi-port counting barrier register file
module fractal_sync_cnt_local_rf
  import fractal_sync_pkg::*;
#(
  parameter int N_REGS      = 4,
  parameter int ID_WIDTH    = 2,
  parameter int N_PORTS     = 2,
  parameter int CNT_WIDTH   = 3,
  parameter int DEFAULT_THR = 2
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic [N_PORTS-1:0]               req_i,
  input  logic [N_PORTS-1:0][ID_WIDTH-1:0] id_i,
  output logic [N_PORTS-1:0]               resp_valid_o,
  output logic [N_PORTS-1:0]               resp_done_o,
  output logic [N_PORTS-1:0]               resp_ovf_o,
  output logic [N_PORTS-1:0]               resp_id_err_o,
  output logic [N_PORTS-1:0]               resp_merged_o,
  input  logic                             cfg_we_i,
  input  logic [ID_WIDTH-1:0]              cfg_idx_i,
  input  logic [CNT_WIDTH-1:0]             cfg_thr_i,
  output logic                             cfg_err_o,
  output logic [N_REGS-1:0]                pending_o
);
  logic [N_PORTS-1:0]                valid, id_err, leader, merged;
  logic [N_PORTS-1:0][CNT_WIDTH-1:0] inc;
  logic [N_REGS-1:0][CNT_WIDTH-1:0]  cnt, thr, slot_inc;
  logic [N_REGS-1:0][CNT_WIDTH:0]    sum;
  logic [N_REGS-1:0]                 hit;
  upd_e                              upd [N_REGS];
  resp_t                             resp_d [N_PORTS];
  resp_t                             resp_q [N_PORTS];
  logic                              cfg_ok;
  fractal_sync_port_merge #(
    .N_REGS(N_REGS), .ID_WIDTH(ID_WIDTH), .N_PORTS(N_PORTS), .CNT_WIDTH(CNT_WIDTH)
  ) u_merge (
    .req_i(req_i), .id_i(id_i), .valid_o(valid), .id_err_o(id_err),
    .leader_o(leader), .merged_o(merged), .inc_o(inc)
  );
  always_comb begin
    hit      = '0;
    slot_inc = '0;
    for (int s = 0; s < N_REGS; s++)
      for (int p = 0; p < N_PORTS; p++)
        if (leader[p] && id_i[p] == ID_WIDTH'(s)) begin
          hit[s]      = 1'b1;
          slot_inc[s] = inc[p];
        end
  end
  for (genvar s = 0; s < N_REGS; s++) begin : g_slot
    assign sum[s]       = {1'b0, cnt[s]} + {1'b0, slot_inc[s]};
    assign upd[s]       = sum[s] < {1'b0, thr[s]} ? PEND : sum[s] == {1'b0, thr[s]} ? DONE : OVF;
    assign pending_o[s] = |cnt[s];
  end
  always_comb begin
    for (int p = 0; p < N_PORTS; p++) begin
      resp_d[p] = '{valid: req_i[p], done: 1'b0, ovf: 1'b0, id_err: id_err[p], merged: merged[p]};
      for (int s = 0; s < N_REGS; s++)
        if (valid[p] && id_i[p] == ID_WIDTH'(s)) begin
          resp_d[p].done = upd[s] != PEND;
          resp_d[p].ovf  = upd[s] == OVF;
        end
    end
  end
  // a write is only safe on an idle slot that no port touches this cycle
  always_comb begin
    cfg_ok = 1'b0;
    for (int s = 0; s < N_REGS; s++)
      if (cfg_idx_i == ID_WIDTH'(s)) cfg_ok = cfg_thr_i != '0 && cnt[s] == '0 && !hit[s];
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt       <= '0;
      cfg_err_o <= 1'b0;
      for (int s = 0; s < N_REGS; s++) thr[s] <= CNT_WIDTH'(DEFAULT_THR);
      for (int p = 0; p < N_PORTS; p++) resp_q[p] <= '0;
    end else begin
      for (int s = 0; s < N_REGS; s++) begin
        if (hit[s]) cnt[s] <= upd[s] == PEND ? sum[s][CNT_WIDTH-1:0] : '0;
        if (cfg_we_i && cfg_ok && cfg_idx_i == ID_WIDTH'(s)) thr[s] <= cfg_thr_i;
      end
      for (int p = 0; p < N_PORTS; p++) resp_q[p] <= resp_d[p];
      cfg_err_o <= cfg_we_i && !cfg_ok;
    end
  end
  for (genvar p = 0; p < N_PORTS; p++) begin : g_out
    assign resp_valid_o[p]  = resp_q[p].valid;
    assign resp_done_o[p]   = resp_q[p].done;
    assign resp_ovf_o[p]    = resp_q[p].ovf;
    assign resp_id_err_o[p] = resp_q[p].id_err;
    assign resp_merged_o[p] = resp_q[p].merged;
  end
endmodule

// File: tb/tb_fractal_sync_cnt_local_rf.sv
// tb_fractal_sync_cnt_local_rf: directed and random arrivals checked against a slot-level model
module tb_fractal_sync_cnt_local_rf;
  logic            clk_i = 1'b0;
  logic            rst_i;
  logic [1:0]      req_i;
  logic [1:0][2:0] id_i;
  logic [1:0]      resp_valid_o, resp_done_o, resp_ovf_o, resp_id_err_o, resp_merged_o;
  logic            cfg_we_i;
  logic [2:0]      cfg_idx_i;
  logic [2:0]      cfg_thr_i;
  logic            cfg_err_o;
  logic [3:0]      pending_o;
  int n_assert = 0;
  int n_fail   = 0;
  int cnt_m [4];
  int thr_m [4];
  fractal_sync_cnt_local_rf #(
    .N_REGS(4), .ID_WIDTH(3), .N_PORTS(2), .CNT_WIDTH(3), .DEFAULT_THR(2)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .id_i(id_i),
    .resp_valid_o(resp_valid_o), .resp_done_o(resp_done_o), .resp_ovf_o(resp_ovf_o),
    .resp_id_err_o(resp_id_err_o), .resp_merged_o(resp_merged_o),
    .cfg_we_i(cfg_we_i), .cfg_idx_i(cfg_idx_i), .cfg_thr_i(cfg_thr_i),
    .cfg_err_o(cfg_err_o), .pending_o(pending_o)
  );
  always #5 clk_i = ~clk_i;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic model_reset();
    for (int s = 0; s < 4; s++) begin
      cnt_m[s] = 0;
      thr_m[s] = 2;
    end
  endtask
  // one cycle: drive inputs, predict from barrier rules, check after the edge
  task automatic step(input logic [1:0] rq, input int i0, input int i1,
                      input logic we, input int ci, input int ct);
    int id [2];
    bit v [2];
    int n [4];
    bit sd [4];
    bit so [4];
    logic [1:0] ev, eerr, em, ed, eo;
    logic ecfg;
    logic [3:0] ep;
    id[0] = i0;
    id[1] = i1;
    req_i = rq;
    id_i[0] = 3'(i0);
    id_i[1] = 3'(i1);
    cfg_we_i = we;
    cfg_idx_i = 3'(ci);
    cfg_thr_i = 3'(ct);
    for (int s = 0; s < 4; s++) begin
      n[s] = 0;
      sd[s] = 0;
      so[s] = 0;
    end
    for (int p = 0; p < 2; p++) begin
      v[p] = rq[p] && id[p] < 4;
      if (v[p]) n[id[p]]++;
    end
    ecfg = 1'b0;
    if (we) begin
      ecfg = 1'b1;
      if (ci < 4 && ct != 0) if (cnt_m[ci] == 0 && n[ci] == 0) ecfg = 1'b0;
    end
    for (int s = 0; s < 4; s++)
      if (n[s] > 0) begin
        sd[s] = cnt_m[s] + n[s] >= thr_m[s];
        so[s] = cnt_m[s] + n[s] > thr_m[s];
        cnt_m[s] = sd[s] ? 0 : cnt_m[s] + n[s];
      end
    for (int p = 0; p < 2; p++) begin
      ev[p] = rq[p];
      eerr[p] = rq[p] && !v[p];
      em[p] = 1'b0;
      for (int q = 0; q < p; q++) if (v[p] && v[q] && id[q] == id[p]) em[p] = 1'b1;
      ed[p] = v[p] && sd[v[p] ? id[p] : 0];
      eo[p] = v[p] && so[v[p] ? id[p] : 0];
    end
    if (we && !ecfg) thr_m[ci] = ct;
    for (int s = 0; s < 4; s++) ep[s] = cnt_m[s] != 0;
    @(posedge clk_i);
    #1;
    chk("resp_valid", 32'(resp_valid_o), 32'(ev));
    chk("resp_done", 32'(resp_done_o), 32'(ed));
    chk("resp_ovf", 32'(resp_ovf_o), 32'(eo));
    chk("resp_id_err", 32'(resp_id_err_o), 32'(eerr));
    chk("resp_merged", 32'(resp_merged_o), 32'(em));
    chk("cfg_err", 32'(cfg_err_o), 32'(ecfg));
    chk("pending", 32'(pending_o), 32'(ep));
  endtask
  initial begin
    rst_i = 1'b1;
    req_i = '0;
    id_i = '0;
    cfg_we_i = 1'b0;
    cfg_idx_i = '0;
    cfg_thr_i = '0;
    model_reset();
    repeat (2) @(posedge clk_i);
    #1;
    chk("reset valid", 32'(resp_valid_o), 0);
    chk("reset done", 32'(resp_done_o | resp_ovf_o | resp_id_err_o | resp_merged_o), 0);
    chk("reset cfg_err", 32'(cfg_err_o), 0);
    chk("reset pending", 32'(pending_o), 0);
    rst_i = 1'b0;
    // 3-party barrier on slot 1
    step(2'b00, 0, 0, 1'b1, 1, 3);
    step(2'b01, 1, 0, 1'b0, 0, 0);
    step(2'b10, 0, 1, 1'b0, 0, 0);
    chk("3party not yet", 32'(resp_done_o), 0);
    step(2'b01, 1, 0, 1'b0, 0, 0);
    chk("3party done", 32'(resp_done_o), 1);
    // default threshold 2 on slot 2
    step(2'b01, 2, 0, 1'b0, 0, 0);
    chk("slot2 pending", 32'(pending_o[2]), 1);
    step(2'b00, 0, 0, 1'b0, 0, 0);
    step(2'b10, 0, 2, 1'b0, 0, 0);
    chk("slot2 done", 32'(resp_done_o), 2);
    // merged pair on slot 1 with threshold back at 2
    step(2'b00, 0, 0, 1'b1, 1, 2);
    step(2'b11, 1, 1, 1'b0, 0, 0);
    chk("merged flags", 32'(resp_merged_o), 2);
    // overshoot on slot 3
    step(2'b01, 3, 0, 1'b0, 0, 0);
    step(2'b11, 3, 3, 1'b0, 0, 0);
    chk("ovf pair", 32'(resp_ovf_o), 3);
    // id errors and rejected configuration
    step(2'b01, 5, 0, 1'b0, 0, 0);
    step(2'b11, 6, 4, 1'b1, 2, 0);
    step(2'b01, 0, 0, 1'b0, 0, 0);
    step(2'b00, 0, 0, 1'b1, 0, 5);
    step(2'b00, 0, 0, 1'b1, 5, 3);
    step(2'b10, 0, 0, 1'b0, 0, 0);
    step(2'b01, 2, 0, 1'b1, 2, 4);
    step(2'b10, 0, 2, 1'b0, 0, 0);
    // asynchronous reset with slot 0 pending
    step(2'b01, 0, 0, 1'b0, 0, 0);
    #2;
    rst_i = 1'b1;
    #1;
    chk("async pending", 32'(pending_o), 0);
    chk("async resp", 32'(resp_valid_o), 0);
    model_reset();
    #3;
    rst_i = 1'b0;
    step(2'b01, 0, 0, 1'b0, 0, 0);
    chk("post reset done", 32'(resp_done_o), 0);
    for (int k = 0; k < 400; k++)
      step(2'($urandom), int'($urandom_range(0, 5)), int'($urandom_range(0, 5)),
           1'($urandom_range(0, 3) == 0), int'($urandom_range(0, 4)), int'($urandom_range(0, 7)));
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
